maxpool_stream: RTL and testbench
=================================

Name: maxpool_stream

Overview:
- Non-overlapping 1-D max-pool stage that sits directly downstream of the convolution layer. It consumes the conv's ReLU'd output stream over a valid/ready handshake.
- For each input vector of N samples, it emits floor(N/K) pooled samples (the signed maximum of each K-sample window). Output also uses valid/ready, so the block can feed a further layer or the testbench.
- Fully streaming: one input per cycle when not back-pressured; no vector buffering.

Parameters:
- T, 16, data width in bits (signed two's complement, input and output).
- N, 25, samples per input vector (equals conv output count SIZE_X-SIZE_F+1).
- K, 2, pool window and stride; 1 <= K <= N.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- x_data  input  T  signed input sample.
- x_valid  input  1  upstream sample valid.
- x_ready  output  1  block can accept a sample this cycle.
- y_data  output  T  signed pooled result.
- y_valid  output  1  y_data valid.
- y_ready  input  1  downstream accepts y_data.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Handshake:
  - Input transfer when x_valid && x_ready.
  - Output transfer when y_valid && y_ready.
  - y_data and y_valid are held stable while y_valid && !y_ready.
- x_ready = !y_valid || y_ready (combinational). This allows a new input in the same cycle an output drains, for full 1-sample/cycle throughput.
- State:
  - acc (T bits, signed) running max.
  - w counter, 0..K-1: position in window.
  - n counter, 0..N-1: position in vector.
  - y_data and y_valid registers.
- On input transfer:
  - If n >= M*K, where M = N/K (integer division), the sample is in the trailing remainder. Consume and discard it; acc and w are unchanged.
  - Else if w == 0: acc <= x_data.
  - Else: acc <= max(acc, x_data), using a signed compare; ties keep either (equal value).
  - If w == K-1 and n < M*K: y_data <= max(acc, x_data), or x_data when K == 1; y_valid <= 1; w <= 0.
  - Otherwise w <= w+1 (when n < M*K).
  - n <= (n == N-1) ? 0 : n+1. The wrap starts a new vector; w is 0 at that point by construction.
- On output transfer with no new result the same cycle: y_valid <= 0.
  - Simultaneous output transfer and new result: y_valid stays 1 and y_data takes the new value.
- Latency: y_valid rises the cycle after the K-th sample of a window is accepted.
- Arithmetic:
  - max is a pure signed compare; no saturation or width growth.
  - Negative inputs are legal (block is not ReLU-dependent).
- Reset values: y_valid=0, y_data=0, acc=0, w=0, n=0. x_ready is therefore 1 after reset.
  - Reset mid-vector discards the partial window and restarts counting at the next accepted sample.
- x_valid low mid-window: state holds indefinitely; no timeout.
- Edge cases:
  - K == N: exactly one output per vector.
  - K == 1: pass-through with 1-cycle latency; M = N, no discard.

Test Plan:
- Defaults. Stream 0,5,3,3,-2,7,9,1, …, 25 samples back-to-back with y_ready=1.
  -> Outputs 5,3,7,9, …, 12 outputs total; 25th sample accepted (x_ready=1) and no output produced for it.
- Back-pressure. Hold y_ready=0 after the first output (value 5).
  -> y_data=5 held; x_ready=0; no further inputs accepted. Raising y_ready drains 5 and accepts the next sample the same cycle.
- Signed compare. Window pairs (-3,-7), (-32768,32767), (100,100).
  -> Outputs -3, 32767, 100.
- Two consecutive vectors (50 samples), random y_ready toggling.
  -> 24 outputs matching the golden model. The sample at index 25 (first of vector 2) starts a new window; samples at index 24 and 49 are discarded.
- Reset mid-window: accept 1 sample (value 40), assert reset for 1 cycle, then send 25 samples all 10.
  -> y_valid=0 during and after reset; 12 outputs of 10; 40 never appears.
- Parameter sweep K=1 and K=25 (N=25), ramp 0..24.
  -> K=1: 25 outputs 0..24, each 1 cycle after its input. K=25: single output 24.

Source files
------------

// File: rtl/maxpool_stream.sv
// maxpool_stream: non-overlapping 1-D signed max-pool over a valid/ready stream
module maxpool_stream #(
  parameter int T = 16,
  parameter int N = 25,
  parameter int K = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);
  localparam int M  = N / K;
  localparam int MK = M * K;
  localparam int WW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  logic signed [T-1:0] acc;
  logic signed [T-1:0] mx;
  logic [WW-1:0]       w;
  logic [NW-1:0]       n;
  logic                x_fire;
  logic                y_fire;
  logic                in_win;
  logic                last;
  assign x_ready = !y_valid || y_ready;
  assign x_fire  = x_valid && x_ready;
  assign y_fire  = y_valid && y_ready;
  // window membership and the running max including the current sample
  always_comb begin
    in_win = 32'(n) < MK;
    last   = w == WW'(K - 1);
    mx     = (w == '0) ? x_data : ((x_data > acc) ? x_data : acc);
  end
  // window/vector counters, running max and the held output register
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      w       <= '0;
      n       <= '0;
      y_data  <= '0;
      y_valid <= 1'b0;
    end else begin
      if (x_fire) begin
        if (in_win) begin
          acc <= mx;
          w   <= last ? '0 : w + WW'(1);
        end
        n <= (n == NW'(N - 1)) ? '0 : n + NW'(1);
      end
      if (x_fire && in_win && last) begin
        y_data  <= mx;
        y_valid <= 1'b1;
      end else if (y_fire) begin
        y_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: randomized scenario bench against a window-max reference model
module tb_maxpool_stream;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [15:0] xd [3];
  logic signed [15:0] yd [3];
  logic xv [3];
  logic xr [3];
  logic yv [3];
  logic yr [3];
  logic signed [15:0] stim [$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  maxpool_stream #(.T(16), .N(25), .K(2)) d0 (
    .clk(clk), .reset(reset), .x_data(xd[0]), .x_valid(xv[0]), .x_ready(xr[0]),
    .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr[0]));
  maxpool_stream #(.T(16), .N(25), .K(1)) d1 (
    .clk(clk), .reset(reset), .x_data(xd[1]), .x_valid(xv[1]), .x_ready(xr[1]),
    .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr[1]));
  maxpool_stream #(.T(16), .N(25), .K(25)) d2 (
    .clk(clk), .reset(reset), .x_data(xd[2]), .x_valid(xv[2]), .x_ready(xr[2]),
    .y_data(yd[2]), .y_valid(yv[2]), .y_ready(yr[2]));

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin xv[i] = 1'b0; yr[i] = 1'b1; xd[i] = '0; end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_random(input int cnt);
    for (int i = 0; i < cnt; i++) stim.push_back(16'($urandom));
  endtask

  // streams stim into instance s, collects outputs, compares to per-window maxima
  task automatic run_stream(input string name, input int s, input int kk, input bit rnd);
    logic signed [15:0] exp_q [$];
    logic signed [15:0] got [$];
    int acc_t [$];
    int out_t [$];
    logic signed [15:0] mx;
    int m;
    int idx;
    int cyc;
    int idle;
    m = 25 / kk;
    idx = 0;
    cyc = 0;
    idle = 0;
    for (int v = 0; v < stim.size() / 25; v++)
      for (int j = 0; j < m; j++) begin
        mx = stim[v*25 + j*kk];
        for (int i = 1; i < kk; i++) if (stim[v*25 + j*kk + i] > mx) mx = stim[v*25 + j*kk + i];
        exp_q.push_back(mx);
      end
    while (idle < 4 && cyc < 3000) begin
      @(negedge clk);
      yr[s] = rnd ? 1'($urandom) : 1'b1;
      xv[s] = idx < stim.size();
      xd[s] = (idx < stim.size()) ? stim[idx] : 16'sd0;
      #1;
      if (yv[s] && yr[s]) begin got.push_back(yd[s]); out_t.push_back(cyc); end
      if (xv[s] && xr[s]) begin acc_t.push_back(cyc); idx++; end
      idle = (idx == stim.size() && !yv[s]) ? idle + 1 : 0;
      cyc++;
    end
    xv[s] = 1'b0;
    yr[s] = 1'b1;
    tests++;
    if (cyc >= 3000 || idx != stim.size() || got.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s count: got %0d outputs (%0d inputs taken), expected %0d outputs (%0d inputs)",
               name, got.size(), idx, exp_q.size(), stim.size());
    end
    for (int j = 0; j < exp_q.size() && j < got.size(); j++) begin
      tests++;
      if (got[j] !== exp_q[j]) begin
        fails++;
        $display("FAIL %s out[%0d]: got %0d expected %0d", name, j, got[j], exp_q[j]);
      end
      if (!rnd) begin
        tests++;
        if (out_t[j] !== acc_t[(j/m)*25 + (j%m)*kk + kk - 1] + 1) begin
          fails++;
          $display("FAIL %s latency[%0d]: out at %0d expected %0d", name, j, out_t[j],
                   acc_t[(j/m)*25 + (j%m)*kk + kk - 1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin xv[i] = 1'b0; yr[i] = 1'b0; xd[i] = '0; end
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (yv[i] !== 1'b0 || yd[i] !== 16'sd0 || xr[i] !== 1'b1) begin
        fails++;
        $display("FAIL reset[%0d]: y_valid=%b y_data=%0d x_ready=%b expected 0 0 1", i, yv[i], yd[i], xr[i]);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) yr[i] = 1'b1;
  endtask

  task automatic test_defaults();
    int init [8] = '{0, 5, 3, 3, -2, 7, 9, 1};
    do_reset();
    stim = {};
    for (int i = 0; i < 8; i++) stim.push_back(16'(init[i]));
    fill_random(17);
    run_stream("defaults", 0, 2, 1'b0);
  endtask

  task automatic test_back_pressure();
    int vals [6] = '{0, 5, 8, 8, 8, 8};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      xv[0] = 1'b1;
      xd[0] = 16'(vals[c]);
      yr[0] = (c == 5);
      #1;
      if (c >= 2) begin
        tests++;
        if (yv[0] !== 1'b1 || yd[0] !== 16'sd5 || xr[0] !== (c == 5)) begin
          fails++;
          $display("FAIL backpressure c%0d: y_valid=%b y_data=%0d x_ready=%b expected 1 5 %b",
                   c, yv[0], yd[0], xr[0], c == 5);
        end
      end
    end
    @(negedge clk);
    xd[0] = 16'sd2;
    #1;
    tests++;
    if (yv[0] !== 1'b0 || xr[0] !== 1'b1) begin
      fails++;
      $display("FAIL backpressure drain: y_valid=%b x_ready=%b expected 0 1", yv[0], xr[0]);
    end
    @(negedge clk);
    xv[0] = 1'b0;
    #1;
    tests++;
    if (yv[0] !== 1'b1 || yd[0] !== 16'sd8) begin
      fails++;
      $display("FAIL backpressure next: y_valid=%b y_data=%0d expected 1 8", yv[0], yd[0]);
    end
  endtask

  task automatic test_signed();
    int init [6] = '{-3, -7, -32768, 32767, 100, 100};
    do_reset();
    stim = {};
    for (int i = 0; i < 6; i++) stim.push_back(16'(init[i]));
    fill_random(19);
    run_stream("signed", 0, 2, 1'b0);
  endtask

  task automatic test_two_vectors();
    do_reset();
    stim = {};
    fill_random(50);
    run_stream("two_vectors", 0, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    xv[0] = 1'b1;
    xd[0] = 16'sd40;
    @(negedge clk);
    xv[0] = 1'b1;
    xd[0] = 16'sd40;
    reset = 1'b1;
    #1;
    tests++;
    if (yv[0] !== 1'b0) begin fails++; $display("FAIL reset_mid during: y_valid=%b expected 0", yv[0]); end
    @(negedge clk);
    reset = 1'b0;
    xv[0] = 1'b0;
    #1;
    tests++;
    if (yv[0] !== 1'b0) begin fails++; $display("FAIL reset_mid after: y_valid=%b expected 0", yv[0]); end
    stim = {};
    for (int i = 0; i < 25; i++) stim.push_back(16'sd10);
    run_stream("reset_mid", 0, 2, 1'b0);
  endtask

  task automatic test_k_sweep();
    do_reset();
    stim = {};
    for (int i = 0; i < 25; i++) stim.push_back(16'(i));
    run_stream("k1_ramp", 1, 1, 1'b0);
    run_stream("k25_ramp", 2, 25, 1'b0);
    stim = {};
    fill_random(50);
    run_stream("k1_random", 1, 1, 1'b1);
    run_stream("k25_random", 2, 25, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin xv[i] = 1'b0; yr[i] = 1'b1; xd[i] = '0; end
    test_reset();
    test_defaults();
    test_back_pressure();
    test_signed();
    test_two_vectors();
    test_reset_mid();
    test_k_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
